// File: rtl/cost_input_loader_if.sv
// Handshake bundle between the training controller / cost_calculator side and cost_input_loader.
// The slave modport is the loader's view; the master modport is the environment's view.
interface cost_input_loader_if #(
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned VAL_W      = 4,
  parameter int unsigned COST_W     = 8
);
  logic                                   sync_clear;
  logic                                   label_valid;
  logic [3:0]                             label_digit;
  logic                                   label_error;
  logic                                   neuron_valid;
  logic [VAL_W-1:0]                       neuron_value;
  logic                                   neuron_ready;
  logic [0:NUM_DIGITS-1]                  expected_label;
  logic [0:NUM_DIGITS-1][VAL_W-1:0]       digit_weights;
  logic                                   cost_en;
  logic                                   calculation_complete;
  logic [COST_W-1:0]                      cost_output;
  logic                                   cost_valid;
  logic [COST_W-1:0]                      cost_value;
  logic                                   busy;

  modport slave (
    input  sync_clear, label_valid, label_digit, neuron_valid, neuron_value,
           calculation_complete, cost_output,
    output label_error, neuron_ready, expected_label, digit_weights, cost_en,
           cost_valid, cost_value, busy
  );

  modport master (
    output sync_clear, label_valid, label_digit, neuron_valid, neuron_value,
           calculation_complete, cost_output,
    input  label_error, neuron_ready, expected_label, digit_weights, cost_en,
           cost_valid, cost_value, busy
  );
endinterface

// File: rtl/cost_input_loader.sv
// Front end of cost_calculator: one-hot label expansion, serial-to-parallel buffering of
// the output-layer values, start/busy/done handshake and a registered cost result.
module cost_input_loader #(
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned VAL_W      = 4,
  parameter int unsigned COST_W     = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  cost_input_loader_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [IDX_W-1:0]                 r_index;
  logic [0:NUM_DIGITS-1]            r_expected_label;
  logic [0:NUM_DIGITS-1][VAL_W-1:0] r_digit_weights;
  logic [COST_W-1:0]                r_cost_value;
  logic                             r_label_error;

  logic                             w_label_ok;
  logic                             w_label_bad;
  logic                             w_neuron_wr;
  logic                             w_last_wr;
  logic                             w_cost_en;
  logic                             w_cost_valid;
  logic [0:NUM_DIGITS-1]            w_onehot;

  assign w_label_ok  = bus.label_valid && (bus.label_digit <= 4'(NUM_DIGITS - 1));
  assign w_label_bad = bus.label_valid && !w_label_ok;
  assign w_neuron_wr = (r_state == S_COLLECT) && bus.neuron_valid && !bus.sync_clear;
  assign w_last_wr   = w_neuron_wr && (r_index == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_onehot[i] = (32'(bus.label_digit) == i);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cost_en    = 1'b0;
    w_cost_valid = 1'b0;
    case (r_state)
      S_IDLE:      if (w_label_ok) w_next = S_COLLECT;
      S_COLLECT:   if (w_last_wr) w_next = S_START;
      // Hold the start pulse back while downstream still reports itself busy.
      S_START: begin
        if (bus.calculation_complete) begin
          w_cost_en = 1'b1;
          w_next    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: if (!bus.calculation_complete) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.calculation_complete) w_next = S_RESULT;
      S_RESULT: begin
        w_cost_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
    if (bus.sync_clear) begin
      w_next       = S_IDLE;
      w_cost_en    = 1'b0;
      w_cost_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_index          <= '0;
      r_expected_label <= '0;
      r_digit_weights  <= '0;
      r_cost_value     <= '0;
      r_label_error    <= 1'b0;
    end else if (bus.sync_clear) begin
      r_index          <= '0;
      r_expected_label <= '0;
      r_digit_weights  <= '0;
      r_cost_value     <= '0;
      r_label_error    <= 1'b0;
    end else begin
      r_label_error <= (r_state == S_IDLE) && w_label_bad;
      if ((r_state == S_IDLE) && w_label_ok) begin
        r_expected_label <= w_onehot;
        r_index          <= '0;
      end
      if (w_neuron_wr) begin
        r_digit_weights[r_index] <= bus.neuron_value;
        r_index                  <= r_index + 1'b1;
      end
      if ((r_state == S_WAIT_DONE) && bus.calculation_complete) begin
        r_cost_value <= bus.cost_output;
      end
    end
  end

  assign bus.label_error    = r_label_error;
  assign bus.neuron_ready   = (r_state == S_COLLECT);
  assign bus.expected_label = r_expected_label;
  assign bus.digit_weights  = r_digit_weights;
  assign bus.cost_en        = w_cost_en;
  assign bus.cost_valid     = w_cost_valid;
  assign bus.cost_value     = r_cost_value;
  assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_cost_input_loader.sv
// Directed bench for cost_input_loader with a small behavioural cost_calculator stand-in.
// Stand-in cost per neuron: (8*|value-target|+4)/5, target 8 for the label neuron else 0.
module tb_cost_input_loader;
  logic clk;
  logic n_rst;

  cost_input_loader_if #(.NUM_DIGITS(10), .VAL_W(4), .COST_W(8)) bus ();

  cost_input_loader #(.NUM_DIGITS(10), .VAL_W(4), .COST_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int cv_cnt = 0;

  always @(posedge clk) begin
    if (bus.cost_en === 1'b1) en_cnt++;
    if (bus.cost_valid === 1'b1) cv_cnt++;
  end

  // Downstream stand-in: idle = complete high; busy for a few cycles after cost_en.
  logic       stub_busy;
  logic       stub_hold;
  logic [2:0] stub_cnt;
  logic [7:0] stub_cost;

  function automatic logic [7:0] calc_cost(input logic [0:9] lbl, input logic [0:9][3:0] w);
    int unsigned sum;
    int unsigned t;
    int unsigned v;
    int unsigned err;
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      t   = lbl[i] ? 8 : 0;
      v   = 32'(w[i]);
      err = (v > t) ? v - t : t - v;
      sum += (8 * err + 4) / 5;
    end
    return (sum > 255) ? 8'hFF : sum[7:0];
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stub_busy       <= 1'b0;
      stub_cnt        <= 3'd0;
      stub_cost       <= 8'd0;
      bus.cost_output <= 8'd0;
    end else if (stub_busy) begin
      if (stub_cnt == 3'd0) begin
        stub_busy       <= 1'b0;
        bus.cost_output <= stub_cost;
      end else begin
        stub_cnt <= stub_cnt - 3'd1;
      end
    end else if (bus.cost_en) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 3'd3;
      stub_cost <= calc_cost(bus.expected_label, bus.digit_weights);
    end
  end

  assign bus.calculation_complete = !stub_busy && !stub_hold;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_label(input logic [3:0] d);
    bus.label_valid = 1'b1;
    bus.label_digit = d;
    tick();
    bus.label_valid = 1'b0;
  endtask

  task automatic send_neurons(input logic [3:0] vals [10], input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        bus.neuron_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.neuron_valid = 1'b1;
      bus.neuron_value = vals[i];
      tick();
    end
    bus.neuron_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.cost_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if ({bus.cost_en, bus.cost_valid, bus.label_error, bus.neuron_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000",
        {bus.cost_en, bus.cost_valid, bus.label_error, bus.neuron_ready});
    end
    n_cmp++;
    if (bus.cost_value !== 8'h00) begin
      n_fail++; $display("FAIL reset_cost_value: got %h want 00", bus.cost_value);
    end
    n_cmp++;
    if (bus.expected_label !== 10'b0 || bus.digit_weights !== 40'h0) begin
      n_fail++; $display("FAIL reset_buffers: got %b / %h want 0 / 0",
        bus.expected_label, bus.digit_weights);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_label3();
    logic [3:0]      v [10];
    logic [0:9][3:0] exp_w;
    bit              seen;
    int              en0;
    int              cv0;
    for (int i = 0; i < 10; i++) v[i] = 4'h0;
    v[3] = 4'h8;
    for (int i = 0; i < 10; i++) exp_w[i] = v[i];
    en0 = en_cnt;
    cv0 = cv_cnt;
    send_label(4'd3);
    n_cmp++;
    if (bus.expected_label !== 10'b0001000000 || bus.neuron_ready !== 1'b1) begin
      n_fail++; $display("FAIL l3_onehot: got %b ready %b want 0001000000 ready 1",
        bus.expected_label, bus.neuron_ready);
    end
    send_neurons(v, 10, 1'b0);
    n_cmp++;
    if (bus.cost_en !== 1'b1 || bus.neuron_ready !== 1'b0) begin
      n_fail++; $display("FAIL l3_start_latency: cost_en %b ready %b want 1 0",
        bus.cost_en, bus.neuron_ready);
    end
    n_cmp++;
    if (bus.digit_weights !== exp_w) begin
      n_fail++; $display("FAIL l3_weights: got %h want %h", bus.digit_weights, exp_w);
    end
    wait_result(40, seen);
    n_cmp++;
    if (!seen || bus.cost_value !== 8'd0) begin
      n_fail++; $display("FAIL l3_cost: seen %b value %0d want seen 1 value 0", seen, bus.cost_value);
    end
    tick();
    n_cmp++;
    if (en_cnt - en0 !== 1 || cv_cnt - cv0 !== 1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL l3_pulses: en %0d valid %0d busy %b want 1 1 0",
        en_cnt - en0, cv_cnt - cv0, bus.busy);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] v [10];
    bit         seen;
    int         cv0;
    for (int i = 0; i < 10; i++) v[i] = 4'hF;
    cv0 = cv_cnt;
    send_label(4'd0);
    send_neurons(v, 10, 1'b1);
    wait_result(40, seen);
    n_cmp++;
    if (!seen || bus.cost_value !== 8'd228) begin
      n_fail++; $display("FAIL gaps_cost: seen %b value %0d want seen 1 value 228", seen, bus.cost_value);
    end
    repeat (5) tick();
    n_cmp++;
    if (cv_cnt - cv0 !== 1) begin
      n_fail++; $display("FAIL gaps_one_valid: got %0d want 1", cv_cnt - cv0);
    end
  endtask

  task automatic test_label_error();
    bus.neuron_valid = 1'b1;
    bus.neuron_value = 4'h5;
    send_label(4'd12);
    n_cmp++;
    if (bus.label_error !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: label_error %b busy %b want 1 0", bus.label_error, bus.busy);
    end
    tick();
    bus.neuron_valid = 1'b0;
    n_cmp++;
    if (bus.label_error !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL err_single: label_error %b busy %b want 0 0", bus.label_error, bus.busy);
    end
    n_cmp++;
    if (bus.expected_label !== 10'b1000000000 || bus.digit_weights !== {10{4'hF}}) begin
      n_fail++; $display("FAIL err_unchanged: got %b / %h want 1000000000 / ffffffffff",
        bus.expected_label, bus.digit_weights);
    end
  endtask

  task automatic test_sync_clear();
    logic [3:0] v [10];
    bit         seen;
    for (int i = 0; i < 10; i++) v[i] = 4'h6;
    send_label(4'd1);
    send_neurons(v, 5, 1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.digit_weights[4] !== 4'h6) begin
      n_fail++; $display("FAIL clr_partial: busy %b w4 %h want 1 6", bus.busy, bus.digit_weights[4]);
    end
    bus.sync_clear = 1'b1;
    bus.label_valid = 1'b1;
    bus.label_digit = 4'd4;
    tick();
    bus.sync_clear = 1'b0;
    bus.label_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.expected_label !== 10'b0 || bus.digit_weights !== 40'h0
        || bus.cost_value !== 8'h00) begin
      n_fail++; $display("FAIL clr_state: busy %b lbl %b w %h cost %h want 0 0 0 00",
        bus.busy, bus.expected_label, bus.digit_weights, bus.cost_value);
    end
    for (int i = 0; i < 10; i++) v[i] = 4'h2;
    v[7] = 4'h8;
    send_label(4'd7);
    send_neurons(v, 10, 1'b0);
    wait_result(40, seen);
    n_cmp++;
    if (!seen || bus.cost_value !== 8'd36) begin
      n_fail++; $display("FAIL clr_next_cost: seen %b value %0d want seen 1 value 36", seen, bus.cost_value);
    end
    tick();
  endtask

  task automatic test_start_hold();
    logic [3:0] v [10];
    bit         seen;
    int         en0;
    for (int i = 0; i < 10; i++) v[i] = 4'h1;
    v[5] = 4'h9;
    stub_hold = 1'b1;
    en0 = en_cnt;
    send_label(4'd5);
    send_neurons(v, 10, 1'b0);
    repeat (3) tick();
    n_cmp++;
    if (en_cnt - en0 !== 0 || bus.cost_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_no_start: en %0d cost_en %b busy %b want 0 0 1",
        en_cnt - en0, bus.cost_en, bus.busy);
    end
    n_cmp++;
    if (bus.cost_value !== 8'd36) begin
      n_fail++; $display("FAIL hold_value_kept: got %0d want 36", bus.cost_value);
    end
    stub_hold = 1'b0;
    #1;
    n_cmp++;
    if (bus.cost_en !== 1'b1) begin
      n_fail++; $display("FAIL hold_release_start: got %b want 1", bus.cost_en);
    end
    wait_result(40, seen);
    n_cmp++;
    if (!seen || bus.cost_value !== 8'd20 || en_cnt - en0 !== 1) begin
      n_fail++; $display("FAIL hold_cost: seen %b value %0d en %0d want 1 20 1",
        seen, bus.cost_value, en_cnt - en0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] v [10];
    bit         seen;
    int         cv0;
    for (int i = 0; i < 10; i++) v[i] = 4'h0;
    cv0 = cv_cnt;
    send_label(4'd9);
    send_neurons(v, 10, 1'b0);
    tick();
    tick();
    n_rst = 1'b0;
    #2;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.expected_label !== 10'b0) begin
      n_fail++; $display("FAIL rst_async: busy %b lbl %b want 0 0", bus.busy, bus.expected_label);
    end
    tick();
    n_rst = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (cv_cnt - cv0 !== 0) begin
      n_fail++; $display("FAIL rst_no_valid: got %0d want 0", cv_cnt - cv0);
    end
    send_label(4'd9);
    send_neurons(v, 10, 1'b0);
    wait_result(40, seen);
    n_cmp++;
    if (!seen || bus.cost_value !== 8'd13) begin
      n_fail++; $display("FAIL rst_next_cost: seen %b value %0d want seen 1 value 13", seen, bus.cost_value);
    end
    send_label(4'd2);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.expected_label !== 10'b0000000001) begin
      n_fail++; $display("FAIL rst_label_in_result: busy %b lbl %b want 0 0000000001",
        bus.busy, bus.expected_label);
    end
  endtask

  initial begin
    n_rst            = 1'b0;
    stub_hold        = 1'b0;
    bus.sync_clear   = 1'b0;
    bus.label_valid  = 1'b0;
    bus.label_digit  = 4'd0;
    bus.neuron_valid = 1'b0;
    bus.neuron_value = 4'd0;
    test_reset();
    test_label3();
    test_gaps();
    test_label_error();
    test_sync_clear();
    test_start_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
